// File: rtl/quick_rs232_rx.sv
// quick_rs232_rx: standalone RS-232 receiver.
// The receiver oversamples rx through a 2-FF synchronizer and deframes the
// start, data, optional parity and stop bits. Each byte is presented in a
// holding register together with its error flags and a read handshake.
// Optional macro QUICK_RS232_RX_CTS_EN: when defined, cts is a registered
// !rx_valid (reset value 0). When undefined, cts is tied high.
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   rx               serial line input, idle high, asynchronous to clk
//   cts              clear to send (1 = a frame can be accepted)
//   rx_read          consume pulse for the held byte
//   rx_data          last accepted byte, LSB received first
//   rx_valid         rx_data holds an unread byte
//   rx_parity_error  parity mismatch for the held byte
//   rx_frame_error   first stop bit sampled 0 for the held byte
//   rx_overrun       one-cycle pulse when a completed frame is dropped
//   rx_busy          a frame is in progress (state is not IDLE)
module quick_rs232_rx #(
  parameter int unsigned CLK_FREQ          = 50000000,
  parameter int unsigned DEFAULT_BYTE_LEN  = 8,
  parameter int unsigned DEFAULT_PARITY    = 1,
  parameter int unsigned DEFAULT_BAUD_RATE = 9600
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic                        cts,
  input  logic                        rx_read,
  output logic [DEFAULT_BYTE_LEN-1:0] rx_data,
  output logic                        rx_valid,
  output logic                        rx_parity_error,
  output logic                        rx_frame_error,
  output logic                        rx_overrun,
  output logic                        rx_busy
);

  localparam int unsigned TICKS    = CLK_FREQ / DEFAULT_BAUD_RATE;
  localparam int unsigned HALF     = TICKS / 2;
  localparam int unsigned BL       = DEFAULT_BYTE_LEN;
  localparam logic [31:0] CNT_HALF = 32'(HALF - 1);
  localparam logic [31:0] CNT_BIT  = 32'(TICKS - 1);
  localparam logic [3:0]  IDX_LAST = 4'(BL - 1);
  localparam bit          PAR_EN   = (DEFAULT_PARITY != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_sync1;
  logic            r_sync2;
  logic [31:0]     r_cnt;
  logic [31:0]     w_cnt_nxt;
  logic [3:0]      r_idx;
  logic [3:0]      w_idx_nxt;
  logic [BL-1:0]   r_shift;
  logic            r_par_err;
  logic [BL-1:0]   r_data;
  logic            r_valid;
  logic            r_pe;
  logic            r_fe;
  logic            r_overrun;
  logic            r_busy;
  logic            w_shift_en;
  logic            w_par_en;
  logic            w_deliver;
  logic            w_par_xor;
  logic            w_par_err;
  logic            w_load;
  logic            w_valid_nxt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, bit timing and sampling strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 32'd1;
    w_idx_nxt   = r_idx;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_deliver   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (!r_sync2) w_state_nxt = ST_START;
      end
      ST_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (r_cnt == CNT_HALF) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = r_sync2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == CNT_BIT) begin
          w_cnt_nxt  = '0;
          w_shift_en = 1'b1;
          w_idx_nxt  = r_idx + 4'd1;
          if (r_idx == IDX_LAST) w_state_nxt = PAR_EN ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (r_cnt == CNT_BIT) begin
          w_cnt_nxt   = '0;
          w_par_en    = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_cnt == CNT_BIT) begin
          w_cnt_nxt   = '0;
          w_deliver   = 1'b1;
          w_state_nxt = r_sync2 ? ST_IDLE : ST_BREAK_WAIT;
        end
      end
      ST_BREAK_WAIT: begin
        // Hold here on a low line so a break cannot retrigger a frame.
        w_cnt_nxt = '0;
        if (r_sync2) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Parity check against the completed data word.
  always_comb begin
    w_par_xor = (^r_shift) ^ r_sync2;
    case (DEFAULT_PARITY)
      32'd1:   w_par_err = w_par_xor;
      32'd2:   w_par_err = !w_par_xor;
      32'd3:   w_par_err = !r_sync2;
      32'd4:   w_par_err = r_sync2;
      default: w_par_err = 1'b0;
    endcase
  end

  // A delivery is accepted when the holder is empty or drained this cycle.
  always_comb begin
    w_load      = w_deliver && (!r_valid || rx_read);
    w_valid_nxt = r_valid;
    if (w_load)       w_valid_nxt = 1'b1;
    else if (rx_read) w_valid_nxt = 1'b0;
  end

  // Synchronizer, datapath and holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par_err <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_pe      <= 1'b0;
      r_fe      <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      // Right shift: after BL bits the first received bit sits at bit 0.
      if (w_shift_en) r_shift <= {r_sync2, r_shift[BL-1:1]};
      if (w_par_en)   r_par_err <= w_par_err;
      if (w_load) begin
        r_data <= r_shift;
        r_pe   <= r_par_err;
        r_fe   <= !r_sync2;
      end
      r_valid   <= w_valid_nxt;
      r_overrun <= w_deliver && r_valid && !rx_read;
      r_busy    <= (w_state_nxt != ST_IDLE);
    end
  end

`ifdef QUICK_RS232_RX_CTS_EN
  logic r_cts;

  // Flow control mirrors the holding register: clear only when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cts <= 1'b0;
    else     r_cts <= !w_valid_nxt;
  end

  assign cts = r_cts;
`else
  assign cts = 1'b1;
`endif

  assign rx_data         = r_data;
  assign rx_valid        = r_valid;
  assign rx_parity_error = r_pe;
  assign rx_frame_error  = r_fe;
  assign rx_overrun      = r_overrun;
  assign rx_busy         = r_busy;

endmodule

// File: tb/tb_quick_rs232_rx.sv
// Self-checking bench for quick_rs232_rx (TICKS=10, HALF=5, 8 bits, even parity).
module tb_quick_rs232_rx;

  localparam int unsigned TICKS = 10;
`ifdef QUICK_RS232_RX_CTS_EN
  localparam bit CTS_EN = 1'b1;
`else
  localparam bit CTS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       cts;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_error;
  logic       rx_frame_error;
  logic       rx_overrun;
  logic       rx_busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_ovr   = 0;
  int   rise_cyc = -1;
  logic prev_valid = 1'b0;
  exp_t sb[$];

  quick_rs232_rx #(
    .CLK_FREQ(1000000),
    .DEFAULT_BYTE_LEN(8),
    .DEFAULT_PARITY(1),
    .DEFAULT_BAUD_RATE(100000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .cts(cts),
    .rx_read(rx_read),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_parity_error(rx_parity_error),
    .rx_frame_error(rx_frame_error),
    .rx_overrun(rx_overrun),
    .rx_busy(rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rising rx_valid must match the oldest expected byte.
  always @(posedge clk) begin
    #1;
    if (rx_overrun === 1'b1) n_ovr++;
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_cyc = cyc;
      check("delivery_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("sb_data", 32'(rx_data), 32'(e.d));
        check("sb_parity_err", 32'(rx_parity_error), 32'(e.pe));
        check("sb_frame_err", 32'(rx_frame_error), 32'(e.fe));
      end
    end
    prev_valid = rx_valid;
  end

  initial begin
    #300us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic hold(input logic v);
    rx = v;
    repeat (TICKS) @(negedge clk);
  endtask

  // Full frame; rx is left at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            output int e0);
    @(negedge clk);
    e0 = cyc + 1;
    hold(1'b0);
    for (int i = 0; i < 8; i++) hold(d[i]);
    hold(par);
    hold(stop);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (rx_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rx_valid), 32'd1);
  endtask

  task automatic do_read();
    @(negedge clk);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  initial begin
    int e0;
    int ovr0;
    rst = 1'b1;
    rx = 1'b1;
    rx_read = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(rx_data), 32'h0);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_pe", 32'(rx_parity_error), 32'd0);
    check("rst_fe", 32'(rx_frame_error), 32'd0);
    check("rst_overrun", 32'(rx_overrun), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    check("rst_cts", 32'(cts), CTS_EN ? 32'd0 : 32'd1);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_cts", 32'(cts), 32'd1);

    // 0xA5 with correct even parity; latency check on the rising edge.
    sb.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
    send_frame(8'hA5, 1'b0, 1'b1, e0);
    wait_valid("a5_valid");
    check("a5_rise_edge", 32'(rise_cyc - e0), 32'd107);
    check("a5_busy_after", 32'(rx_busy), 32'd0);
    check("a5_cts_held", 32'(cts), CTS_EN ? 32'd0 : 32'd1);
    do_read();
    check("a5_read_valid", 32'(rx_valid), 32'd0);
    check("a5_read_cts", 32'(cts), 32'd1);

    // 0x01 has odd weight, so parity bit 0 is an even-parity error.
    sb.push_back('{d: 8'h01, pe: 1'b1, fe: 1'b0});
    send_frame(8'h01, 1'b0, 1'b1, e0);
    wait_valid("p01_valid");
    do_read();

    // 0x3C with stop bit 0 and a line held low: frame error, then break wait.
    sb.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b1});
    ovr0 = n_ovr;
    send_frame(8'h3C, 1'b0, 1'b0, e0);
    wait_valid("brk_valid");
    repeat (40) @(negedge clk);
    check("brk_busy_low", 32'(rx_busy), 32'd1);
    check("brk_data_kept", 32'(rx_data), 32'h3C);
    check("brk_no_overrun", 32'(n_ovr - ovr0), 32'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_busy_release", 32'(rx_busy), 32'd0);
    do_read();
    check("brk_read_valid", 32'(rx_valid), 32'd0);
    repeat (5) @(negedge clk);

    // Three-cycle glitch must be rejected at the mid-start sample (E7).
    @(negedge clk);
    e0 = cyc + 1;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    wait_cyc(e0 + 4);
    check("glitch_busy_mid", 32'(rx_busy), 32'd1);
    wait_cyc(e0 + 7);
    check("glitch_busy_e7", 32'(rx_busy), 32'd0);
    check("glitch_valid", 32'(rx_valid), 32'd0);
    repeat (5) @(negedge clk);

    // Two frames without a read: the second is dropped with one overrun pulse.
    sb.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
    ovr0 = n_ovr;
    send_frame(8'h11, 1'b0, 1'b1, e0);
    send_frame(8'h22, 1'b0, 1'b1, e0);
    repeat (3) @(negedge clk);
    check("ovr_pulses", 32'(n_ovr - ovr0), 32'd1);
    check("ovr_data_kept", 32'(rx_data), 32'h11);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    do_read();
    check("ovr_read_valid", 32'(rx_valid), 32'd0);
    repeat (5) @(negedge clk);

    // Reset during data bit 4 of 0x55: no delivery, outputs back to reset.
    @(negedge clk);
    hold(1'b0);
    for (int i = 0; i < 4; i++) hold(i[0] ? 1'b0 : 1'b1);
    rx = 1'b1;
    repeat (TICKS / 2) @(negedge clk);
    check("mid_busy", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(rx_busy), 32'd0);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_data", 32'(rx_data), 32'h0);
    check("mid_rst_cts", 32'(cts), CTS_EN ? 32'd0 : 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_valid", 32'(rx_valid), 32'd0);
    check("post_rst_cts", 32'(cts), 32'd1);

    sb.push_back('{d: 8'h66, pe: 1'b0, fe: 1'b0});
    send_frame(8'h66, 1'b0, 1'b1, e0);
    wait_valid("f66_valid");
    check("f66_cts_held", 32'(cts), CTS_EN ? 32'd0 : 32'd1);
    do_read();
    check("f66_read_valid", 32'(rx_valid), 32'd0);
    check("f66_read_cts", 32'(cts), 32'd1);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/quick_rs232_rx.md
# quick_rs232_rx

Standalone RS-232 receiver: oversamples the asynchronous `rx` line and deframes start / data / parity / stop bits. It presents each received byte in a holding register with error flags and a read handshake, and optionally drives `cts` for hardware flow control. It is the receive-direction counterpart of the QuickRS232 transmit path. It sits between the external RS-232 pin and the inner module, or a FIFO.

## Interface
Parameters:
- `CLK_FREQ`, 50000000 — `clk` frequency, Hz.
- `DEFAULT_BYTE_LEN`, 8 — data bits per frame, 5..9.
- `DEFAULT_PARITY`, 1 — 0 none, 1 even, 2 odd, 3 mark, 4 space.
- `DEFAULT_BAUD_RATE`, 9600 — bit/s.

Ports:
- `clk`  in  1  — the single clock.
- `rst`  in  1  — reset, asynchronous, active-high.
- `rx`  in  1  — serial line; idle high; asynchronous to `clk`.
- `cts`  out  1  — clear to send; 1 means the receiver can accept a frame.
- `rx_read`  in  1  — consume pulse for the held byte.
- `rx_data`  out  DEFAULT_BYTE_LEN  — last accepted byte, LSB received first.
- `rx_valid`  out  1  — `rx_data` holds an unread byte.
- `rx_parity_error`  out  1  — parity mismatch for the held byte.
- `rx_frame_error`  out  1  — first stop bit sampled 0 for the held byte.
- `rx_overrun`  out  1  — one-cycle pulse when a completed frame is dropped.
- `rx_busy`  out  1  — frame in progress (any state except IDLE).

## Operation
- `TICKS = CLK_FREQ/DEFAULT_BAUD_RATE`, integer division. `HALF = TICKS/2`.
- Bit counter: 32 bits. Data index: 4 bits.
- `rx` passes through a 2-FF synchronizer, reset to 1; its output is `rx_s`.
- States and transitions:
  - IDLE: if `rx_s`=0, go to START; cnt←0.
  - START: cnt++. At cnt==HALF-1, sample `rx_s`. If 1 (glitch), go to IDLE. Else cnt←0, idx←0, go to DATA.
  - DATA: at cnt==TICKS-1, shift[idx]←`rx_s`, cnt←0, idx++. After bit DEFAULT_BYTE_LEN-1, go to PARITY; if parity is none, go to STOP.
  - PARITY: at cnt==TICKS-1, compute error:
    - even: XOR(data, p)≠0
    - odd: XOR(data, p)≠1
    - mark: p≠1
    - space: p≠0
    - Then go to STOP.
  - STOP: at cnt==TICKS-1, sample the stop bit, then deliver. If the stop bit is 1, go to IDLE. If it is 0, go to BREAK_WAIT.
  - BREAK_WAIT: stay until `rx_s`=1, then go to IDLE. This prevents retriggering on a held-low line.
- Only the first stop bit is checked. Extra stop bits are treated as idle line.
- Deliver, when `rx_valid`=0 or `rx_read`=1 in the same cycle:
  - `rx_data`←shift.
  - Error flags are loaded with the byte.
  - `rx_valid`←1.
  - Bytes with errors are still delivered.
- Deliver when `rx_valid`=1 and `rx_read`=0:
  - The new byte is discarded.
  - Old data and flags are kept.
  - `rx_overrun`=1 for one cycle.
- `rx_read` while `rx_valid`=1 and no delivery: `rx_valid`←0 next edge. Data and flags stay unchanged.
- `rx_read` while `rx_valid`=0: ignored.

## Timing
- Reset values:
  - `rx_data`=0; `rx_valid`=0; all error flags 0; `rx_overrun`=0; `rx_busy`=0.
  - State IDLE; synchronizer FFs 1.
  - `cts`=0 with the macro, 1 without.
- Reset asserted mid-frame: the frame is abandoned immediately and nothing is delivered.
- Let E0 be the first `clk` edge that captures `rx`=0 in sync FF1.
  - START is entered at E2.
  - The start bit is sampled at E(2+HALF).
  - Data bit k (1-based) is sampled at E(2+HALF+k·TICKS).
  - `rx_valid` rises on edge E(2+HALF+(DEFAULT_BYTE_LEN+P+1)·TICKS), where P=1 if parity is enabled, else 0.
- `rx_busy` is high from E2 until the state returns to IDLE.

## Configuration
- `QUICK_RS232_RX_CTS_EN` defined:
  - `cts` is registered and equals `!rx_valid`.
  - It drops on the edge that sets `rx_valid`.
  - It rises on the edge after the consuming `rx_read`.
  - Its reset value is 0.
- Undefined: `cts` is tied to 1'b1.
- No other behaviour changes.

## Test plan
Bench parameters: CLK_FREQ=1000000, DEFAULT_BAUD_RATE=100000 (TICKS=10, HALF=5), 8 data bits, even parity.
- Frame 0xA5 with parity 0 and stop 1 -> `rx_data`=0xA5, `rx_valid` rises at E107, both error flags 0.
- Frame 0x01 with parity bit 0 -> `rx_data`=0x01, `rx_parity_error`=1, `rx_frame_error`=0.
- Frame 0x3C with stop bit 0, line held low for 50 cycles -> `rx_frame_error`=1. State stays in BREAK_WAIT with no new frame until the line returns high.
- `rx` low for 3 cycles, then high -> `rx_valid` stays 0 and state returns to IDLE by E7.
- Frames 0x11 then 0x22 with no `rx_read` -> `rx_data`=0x11 and one `rx_overrun` pulse. Then `rx_read` -> `rx_valid`=0 on the next edge.
- Reset asserted at data bit 4 of 0x55 -> all outputs return to reset values, no delivery; the next frame 0x66 is received correctly. With the macro defined, `cts` reads 1 before the frame, 0 while 0x66 is held, and 1 the cycle after `rx_read`.
